seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed BCD seven-segment scan controller with blanking gaps between digits.
// Optional leading-zero suppression when SEG_SCAN_LZ_SUPPRESS_EN is defined.
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [8:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [2:0]            busy_digit
);

    // state    | meaning
    // ST_BLANK | all digits off for BLANK_CYC cycles (anti-ghosting gap)
    // ST_SHOW  | digit idx driven for CLK_DIV cycles with value latched at entry

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int PW      = $clog2(CNT_MAX);

    localparam logic [PW-1:0]    SHOW_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]    BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [8:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;

    logic [3:0]          nib;
    logic                dp_bit;
    logic                blank_dig;
    logic [6:0]          decoded;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        seg_d        = seg_q;
        dig_sel_d    = dig_sel_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        nib          = 4'd0;
        dp_bit       = 1'b0;
        blank_dig    = 1'b0;

        if (load) begin
            shadow_bcd_d = bcd_in;
            shadow_dp_d  = dp_in;
        end

        // Pick the shadow nibble for the digit about to be shown; a load on
        // this same edge only reaches the shadow afterwards.
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib    = shadow_bcd_q[4*k +: 4];
                dp_bit = shadow_dp_q[k];
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
                blank_dig = (k != 0) && ((shadow_bcd_q >> (4*k)) == '0);
`else
                blank_dig = 1'b0;
`endif
            end
        end

        decoded = blank_dig ? 7'h00 : seg_decode(nib);

        case (state_q)
            ST_BLANK: begin
                if (presc_q == BLANK_LAST) begin
                    state_d   = ST_SHOW;
                    presc_d   = '0;
                    seg_d     = {1'b0, dp_bit, decoded};
                    dig_sel_d = DIGITS'(1) << idx_q;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                if (presc_q == SHOW_LAST) begin
                    state_d   = ST_BLANK;
                    presc_d   = '0;
                    seg_d     = '0;
                    dig_sel_d = '0;
                    idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            presc_q      <= '0;
            idx_q        <= '0;
            seg_q        <= '0;
            dig_sel_q    <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_sel_q;
    assign busy_digit = 3'(idx_q);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, CLK_DIV=4, BLANK_CYC=2): timeline model plus literal checks.
module tb_seg_scan_ctrl;

    localparam int DIG  = 4;
    localparam int CD   = 4;
    localparam int BC   = 2;
    localparam int SLOT = CD + BC;
    localparam int PER  = DIG * SLOT;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    localparam logic [8:0] Z_HI = 9'h000;
`else
    localparam logic [8:0] Z_HI = 9'h03F;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic [8:0]  seg_out;
    logic [3:0]  dig_sel;
    logic [2:0]  busy_digit;

    int checks = 0;
    int errors = 0;
    int cur = 0;

    seg_scan_ctrl #(.DIGITS(DIG), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .seg_out(seg_out), .dig_sel(dig_sel), .busy_digit(busy_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Model: position in the scan timeline since reset release decides everything.
    logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    int         n = 0;
    int         mq, md, mr;
    logic [15:0] m_bcd = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_nib;
    logic [8:0]  e_seg = 9'h0;
    logic [3:0]  e_sel = 4'h0;
    logic [2:0]  e_busy = 3'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_bcd = 16'h0; m_dp = 4'h0;
            e_seg = 9'h0; e_sel = 4'h0; e_busy = 3'h0;
        end else begin
            n  = n + 1;
            mq = n % PER;
            md = mq / SLOT;
            mr = mq % SLOT;
            if (mr == BC) begin
                m_nib = 4'((m_bcd >> (4*md)) & 16'hF);
                e_seg = {1'b0, m_dp[md], seg_tab[m_nib]};
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
                if (md > 0 && (m_bcd >> (4*md)) == 16'h0) e_seg[6:0] = 7'h00;
`endif
                e_sel = 4'(1 << md);
            end else if (mr < BC) begin
                e_seg = 9'h0;
                e_sel = 4'h0;
            end
            e_busy = 3'(md);
            if (load) begin
                m_bcd = bcd_in;
                m_dp  = dp_in;
            end
        end
    end

    int   last_rise = -1;
    logic prev0 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_rise = -1;
            prev0     = 1'b0;
        end else begin
            chk("model_seg", 32'(seg_out), 32'(e_seg));
            chk("model_sel", 32'(dig_sel), 32'(e_sel));
            chk("model_busy", 32'(busy_digit), 32'(e_busy));
            chk("onehot", 32'($countones(dig_sel) <= 1), 32'd1);
            if (dig_sel[0] && !prev0) begin
                if (last_rise >= 0) chk("period", 32'(n - last_rise), 32'(PER));
                last_rise = n;
            end
            prev0 = dig_sel[0];
        end
    end

    task automatic at(input int t);
        while (cur < t) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic lit(input string name, input logic [8:0] s, input logic [3:0] d);
        chk({name, "_seg"}, 32'(seg_out), 32'(s));
        chk({name, "_sel"}, 32'(dig_sel), 32'(d));
    endtask

    task automatic start(input logic [15:0] b, input logic [3:0] p);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bcd_in = b; dp_in = p; load = 1'b1;
        #1;
        chk("rst_seg", 32'(seg_out), 32'h0);
        chk("rst_sel", 32'(dig_sel), 32'h0);
        chk("rst_busy", 32'(busy_digit), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cur = 0;
        at(1);
        load = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;

        // Basic scan of 4321
        start(16'h4321, 4'b0000);
        lit("s1_n1", 9'h000, 4'b0000);
        at(2);  lit("s1_d0", 9'h006, 4'b0001);
        chk("s1_busy0", 32'(busy_digit), 32'd0);
        at(5);  lit("s1_d0end", 9'h006, 4'b0001);
        at(6);  lit("s1_gap", 9'h000, 4'b0000);
        chk("s1_busy_gap", 32'(busy_digit), 32'd1);
        at(8);  lit("s1_d1", 9'h05B, 4'b0010);
        at(14); lit("s1_d2", 9'h04F, 4'b0100);
        at(20); lit("s1_d3", 9'h066, 4'b1000);
        chk("s1_busy3", 32'(busy_digit), 32'd3);
        at(26); lit("s1_wrap", 9'h006, 4'b0001);

        // Load mid-dwell of digit1
        at(33); bcd_in = 16'h9999; load = 1'b1;
        at(34); load = 1'b0;
        at(35); lit("mid_keep", 9'h05B, 4'b0010);
        at(38); lit("mid_next", 9'h06F, 4'b0100);

        // Load on the same edge as SHOW entry of digit3
        at(43); bcd_in = 16'h5555; load = 1'b1;
        at(44); load = 1'b0;
        lit("same_edge_old", 9'h06F, 4'b1000);
        at(50); lit("same_edge_new", 9'h06D, 4'b0001);

        // Async reset mid-SHOW
        at(51);
        #2 rst_n = 1'b0;
        #1;
        lit("async_rst", 9'h000, 4'b0000);
        chk("async_busy", 32'(busy_digit), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cur = 0;
        at(1);  lit("ar_blank", 9'h000, 4'b0000);
        at(2);  lit("ar_d0", 9'h03F, 4'b0001);
        at(60);

        // Invalid nibble with dp
        start(16'h00A0, 4'b0010);
        at(2);  lit("inv_d0", 9'h03F, 4'b0001);
        at(8);  lit("inv_d1", 9'h080, 4'b0010);
        at(14); lit("inv_d2", Z_HI, 4'b0100);
        at(20); lit("inv_d3", Z_HI, 4'b1000);
        at(30);

        // Leading zeros
        start(16'h0070, 4'b0000);
        at(2);  lit("lz_d0", 9'h03F, 4'b0001);
        at(8);  lit("lz_d1", 9'h007, 4'b0010);
        at(14); lit("lz_d2", Z_HI, 4'b0100);
        at(20); lit("lz_d3", Z_HI, 4'b1000);
        at(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
